// File: rtl/banked_memory.sv
// banked_memory: banked, line-wide single-port store with a request/reply
// handshake. Read and write requests are captured in one-deep pending
// latches and served one at a time; writes win when both are pending.
// Optional feature macro: BANKED_MEMORY_PARITY_EN (slot MSB holds even
// parity of the word, checked on read). Without it the slot MSB is written 0
// and ignored, and rd_parity_err stays 0.

// Single-port SRAM model: active-low chip enable, write enable and per-bit
// write mask; Q updates the cycle after an enabled read.
module banked_memory_sram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 128,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             cen,
    input  logic             wen,
    input  logic [WIDTH-1:0] bwen,
    input  logic [AW-1:0]    a,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Masked write or synchronous read of the addressed line.
    always_ff @(posedge clk) begin
        if (!cen) begin
            if (!wen) begin
                mem[a] <= (mem[a] & bwen) | (d & ~bwen);
            end else begin
                q <= mem[a];
            end
        end
    end
endmodule

module banked_memory #(
    parameter int WORD_W         = 31,
    parameter int WORDS_PER_LINE = 4,
    parameter int LINE_DEPTH     = 64,
    parameter int BANKS          = 8,
    parameter int ADDR_W         = 12
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wr_data,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_reply,
    output logic              wr_reply,
    output logic              busy,
    output logic              req_overrun,
    output logic              rd_parity_err
);
    localparam int SLOT_W = WORD_W + 1;
    localparam int LINE_W = WORDS_PER_LINE * SLOT_W;
    localparam int WOFF_W = $clog2(WORDS_PER_LINE);
    localparam int LIDX_W = $clog2(LINE_DEPTH);
    localparam int BANK_W = ADDR_W - WOFF_W - LIDX_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_RCAP  = 3'd3,
        ST_REPLY = 3'd4
    } state_t;

    // Even parity bit: makes the total count of ones in {parity, word} even.
    function automatic logic parity_even(input logic [WORD_W-1:0] w);
        return ^w;
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic                wr_pend_r;
    logic                rd_pend_r;
    logic                wr_pend_nxt_s;
    logic                rd_pend_nxt_s;
    logic                wr_take_s;
    logic                rd_take_s;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [ADDR_W-1:0]   rd_addr_r;
    logic [WORD_W-1:0]   wr_data_r;
    logic                reply_wr_r;
    logic [WORD_W-1:0]   rd_data_r;
    logic                rd_reply_r;
    logic                wr_reply_r;
    logic                busy_r;
    logic                overrun_r;
    logic                par_err_r;

    logic [ADDR_W-1:0]   cur_addr_s;
    logic [WOFF_W-1:0]   word_s;
    logic [LIDX_W-1:0]   line_s;
    logic [BANK_W-1:0]   bank_s;
    logic                in_range_s;
    logic                mem_en_s;
    logic                mem_wr_s;
    logic                slot_par_s;
    logic [SLOT_W-1:0]   slot_wr_s;
    logic [LINE_W-1:0]   line_wdata_s;
    logic [LINE_W-1:0]   line_bwen_s;
    logic [BANKS-1:0]    cen_s;
    logic [LINE_W-1:0]   bank_q_s [BANKS];
    logic [LINE_W-1:0]   sel_line_s;
    logic [SLOT_W-1:0]   sel_slot_s;
    logic                rd_par_bad_s;

    // A request is accepted only when its pending latch is free; the REPLY
    // state releases the latch of the access it completes.
    assign wr_take_s     = wr_req && !wr_pend_r;
    assign rd_take_s     = rd_req && !rd_pend_r;
    assign wr_pend_nxt_s = wr_take_s ? 1'b1 :
                           ((state_r == ST_REPLY) && reply_wr_r) ? 1'b0 : wr_pend_r;
    assign rd_pend_nxt_s = rd_take_s ? 1'b1 :
                           ((state_r == ST_REPLY) && !reply_wr_r) ? 1'b0 : rd_pend_r;

    // Next-state logic; IDLE also honours a request arriving this cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (wr_pend_r || wr_req) begin
                    state_nxt_s = ST_WR;
                end else if (rd_pend_r || rd_req) begin
                    state_nxt_s = ST_RD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR:    state_nxt_s = ST_REPLY;
            ST_RD:    state_nxt_s = ST_RCAP;
            ST_RCAP:  state_nxt_s = ST_REPLY;
            ST_REPLY: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Address split (word-in-line, line, bank) of the access being served.
    assign cur_addr_s = (state_r == ST_WR) ? wr_addr_r : rd_addr_r;
    assign word_s     = WOFF_W'(cur_addr_s);
    assign line_s     = LIDX_W'(cur_addr_s >> WOFF_W);
    assign bank_s     = BANK_W'(cur_addr_s >> (WOFF_W + LIDX_W));
    assign in_range_s = {1'b0, bank_s} < (BANK_W + 1)'(BANKS);
    assign mem_en_s   = ((state_r == ST_WR) || (state_r == ST_RD)) && in_range_s;
    assign mem_wr_s   = (state_r == ST_WR);

`ifdef BANKED_MEMORY_PARITY_EN
    assign slot_par_s   = parity_even(wr_data_r);
    assign rd_par_bad_s = in_range_s &&
                          (sel_slot_s[WORD_W] != parity_even(sel_slot_s[WORD_W-1:0]));
`else
    logic unused_par_s;
    assign slot_par_s   = 1'b0;
    assign rd_par_bad_s = 1'b0;
    assign unused_par_s = sel_slot_s[WORD_W];
`endif

    assign slot_wr_s    = {slot_par_s, wr_data_r};
    assign line_wdata_s = {WORDS_PER_LINE{slot_wr_s}};

    // Write mask: only the addressed slot is enabled (active-low).
    always_comb begin
        line_bwen_s = {LINE_W{1'b1}};
        for (int s = 0; s < WORDS_PER_LINE; s++) begin
            line_bwen_s[s*SLOT_W +: SLOT_W] = (word_s == WOFF_W'(s)) ?
                                              {SLOT_W{1'b0}} : {SLOT_W{1'b1}};
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : gen_bank
        assign cen_s[b] = !(mem_en_s && (bank_s == BANK_W'(b)));

        banked_memory_sram #(
            .DEPTH (LINE_DEPTH),
            .WIDTH (LINE_W),
            .AW    (LIDX_W)
        ) u_sram (
            .clk  (clk),
            .cen  (cen_s[b]),
            .wen  (!mem_wr_s),
            .bwen (line_bwen_s),
            .a    (line_s),
            .d    (line_wdata_s),
            .q    (bank_q_s[b])
        );
    end

    // Read mux: pick the addressed bank's Q, then the addressed slot.
    always_comb begin
        sel_line_s = {LINE_W{1'b0}};
        sel_slot_s = {SLOT_W{1'b0}};
        for (int b = 0; b < BANKS; b++) begin
            sel_line_s = sel_line_s |
                         ((bank_s == BANK_W'(b)) ? bank_q_s[b] : {LINE_W{1'b0}});
        end
        for (int s = 0; s < WORDS_PER_LINE; s++) begin
            sel_slot_s = sel_slot_s |
                         ((word_s == WOFF_W'(s)) ? sel_line_s[s*SLOT_W +: SLOT_W]
                                                 : {SLOT_W{1'b0}});
        end
    end

    // FSM state, pending latches and captured request fields.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            wr_pend_r  <= 1'b0;
            rd_pend_r  <= 1'b0;
            wr_addr_r  <= {ADDR_W{1'b0}};
            rd_addr_r  <= {ADDR_W{1'b0}};
            wr_data_r  <= {WORD_W{1'b0}};
            reply_wr_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            wr_pend_r <= wr_pend_nxt_s;
            rd_pend_r <= rd_pend_nxt_s;
            if (wr_take_s) begin
                wr_addr_r <= addr;
                wr_data_r <= wr_data;
            end
            if (rd_take_s) begin
                rd_addr_r <= addr;
            end
            if (state_r == ST_WR) begin
                reply_wr_r <= 1'b1;
            end else if (state_r == ST_RCAP) begin
                reply_wr_r <= 1'b0;
            end
        end
    end

    // Registered handshake outputs, read word, parity flag and status.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data_r  <= {WORD_W{1'b0}};
            rd_reply_r <= 1'b0;
            wr_reply_r <= 1'b0;
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
            par_err_r  <= 1'b0;
        end else begin
            wr_reply_r <= (state_r == ST_WR);
            rd_reply_r <= (state_r == ST_RCAP);
            par_err_r  <= (state_r == ST_RCAP) && rd_par_bad_s;
            busy_r     <= (state_nxt_s != ST_IDLE) || wr_pend_nxt_s || rd_pend_nxt_s;
            if (state_r == ST_RCAP) begin
                rd_data_r <= in_range_s ? sel_slot_s[WORD_W-1:0] : {WORD_W{1'b0}};
            end
            if ((wr_req && wr_pend_r) || (rd_req && rd_pend_r)) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign rd_data       = rd_data_r;
    assign rd_reply      = rd_reply_r;
    assign wr_reply      = wr_reply_r;
    assign busy          = busy_r;
    assign req_overrun   = overrun_r;
    assign rd_parity_err = par_err_r;
endmodule

// File: tb/tb_banked_memory.sv
// Directed self-checking bench for banked_memory (default 8x64x4x31 shape).
// With BANKED_MEMORY_PARITY_EN defined it also corrupts a stored parity bit.
module tb_banked_memory;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rd_req = 1'b0;
    logic        wr_req = 1'b0;
    logic [11:0] addr = 12'd0;
    logic [30:0] wr_data = 31'd0;
    logic [30:0] rd_data;
    logic        rd_reply;
    logic        wr_reply;
    logic        busy;
    logic        req_overrun;
    logic        rd_parity_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [30:0] line_vals [4] = '{31'h0101_0101, 31'h0202_0202, 31'h7F0F_F0F0, 31'h1357_9BDF};

    banked_memory u_dut (
        .clk           (clk),
        .resetn        (resetn),
        .rd_req        (rd_req),
        .wr_req        (wr_req),
        .addr          (addr),
        .wr_data       (wr_data),
        .rd_data       (rd_data),
        .rd_reply      (rd_reply),
        .wr_reply      (wr_reply),
        .busy          (busy),
        .req_overrun   (req_overrun),
        .rd_parity_err (rd_parity_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request at E0; wr_reply in cycle 2; idle (not busy) in cycle 3.
    task automatic do_write(input logic [11:0] a, input logic [30:0] d, input string tag);
        addr = a; wr_data = d; wr_req = 1'b1;
        step();
        wr_req = 1'b0;
        check_eq({tag, ".busy_c1"}, 32'(busy), 32'd1);
        step();
        check_eq({tag, ".wr_reply_c2"}, 32'(wr_reply), 32'd1);
        step();
        check_eq({tag, ".idle_c3"}, 32'({busy, wr_reply}), 32'd0);
    endtask

    // Request at E0; rd_reply with data in cycle 3; idle in cycle 4.
    task automatic do_read(input logic [11:0] a, input logic [30:0] exp, input logic perr, input string tag);
        addr = a; rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        step();
        check_eq({tag, ".no_reply_c2"}, 32'(rd_reply), 32'd0);
        step();
        check_eq({tag, ".rd_reply_c3"}, 32'(rd_reply), 32'd1);
        check_eq({tag, ".rd_data"}, 32'(rd_data), 32'(exp));
        check_eq({tag, ".parity_err"}, 32'(rd_parity_err), 32'(perr));
        step();
        check_eq({tag, ".idle_c4"}, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".rd_data"}, 32'(rd_data), 32'd0);
        check_eq({tag, ".flags"}, 32'({rd_reply, wr_reply, busy, req_overrun, rd_parity_err}), 32'd0);
    endtask

    initial begin
        int replies;
        logic [30:0] got_data;

        step();
        step();
        check_all_zero("reset");
        resetn = 1'b1;
        step();

        do_write(12'o0123, 31'h2AAA_5555, "w0123");
        do_read(12'o0123, 31'h2AAA_5555, 1'b0, "r0123");

        for (int i = 0; i < 4; i++) begin
            do_write(12'o0300 + 12'(i), line_vals[i], "wline");
        end
        for (int i = 0; i < 4; i++) begin
            do_read(12'o0300 + 12'(i), line_vals[i], 1'b0, "rline");
        end

        // Simultaneous read+write to the same word: write first, read sees it.
        do_write(12'o0200, 31'h0, "w0200_init");
        addr = 12'o0200; wr_data = 31'h1; wr_req = 1'b1; rd_req = 1'b1;
        step();
        wr_req = 1'b0; rd_req = 1'b0;
        step();
        check_eq("both.wr_reply_c2", 32'({wr_reply, rd_reply}), 32'b10);
        step();
        step();
        step();
        check_eq("both.no_rd_reply_c5", 32'(rd_reply), 32'd0);
        step();
        check_eq("both.rd_reply_c6", 32'(rd_reply), 32'd1);
        check_eq("both.rd_data", 32'(rd_data), 32'h1);
        check_eq("both.overrun", 32'(req_overrun), 32'd0);
        step();
        check_eq("both.idle_c7", 32'(busy), 32'd0);

        // Out-of-range bank 8: read returns 0, write is discarded.
        do_write(12'o0000, 31'h0ABC_DEF0, "w0000");
        do_read(12'o4000, 31'h0, 1'b0, "r4000");
        do_write(12'o4000, 31'h7FFF_FFFF, "w4000");
        do_read(12'o0000, 31'h0ABC_DEF0, 1'b0, "r0000_after_oor");

        // Two read pulses while a write is in progress: second is dropped.
        addr = 12'o0010; wr_data = 31'h55; wr_req = 1'b1;
        step();
        wr_req = 1'b0; addr = 12'o0300; rd_req = 1'b1;
        step();
        check_eq("ovr.before", 32'(req_overrun), 32'd0);
        addr = 12'o0301;
        step();
        rd_req = 1'b0;
        check_eq("ovr.set", 32'(req_overrun), 32'd1);
        replies = 0;
        got_data = 31'h0;
        for (int i = 0; i < 10; i++) begin
            if (rd_reply) begin
                replies++;
                got_data = rd_data;
            end
            step();
        end
        check_eq("ovr.reply_count", 32'(replies), 32'd1);
        check_eq("ovr.first_addr_data", 32'(got_data), 32'(line_vals[0]));
        check_eq("ovr.sticky", 32'({req_overrun, busy}), 32'b10);

        // Reset during RD: everything clears at once, no reply afterwards.
        addr = 12'o0123; rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        #1 resetn = 1'b0;
        #1 check_all_zero("rst_mid");
        step();
        step();
        check_eq("rst_mid.held", 32'(rd_reply), 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("rst_mid.no_reply", 32'({rd_reply, busy}), 32'd0);
        end
        do_read(12'o0123, 31'h2AAA_5555, 1'b0, "r0123_post_rst");
        do_read(12'o0302, line_vals[2], 1'b0, "r0302_post_rst");

`ifdef BANKED_MEMORY_PARITY_EN
        // Word 'o0123: bank 0, line 20, slot 3 -> parity bit 3*32+31 = 127.
        u_dut.gen_bank[0].u_sram.mem[20][127] = ~u_dut.gen_bank[0].u_sram.mem[20][127];
        do_read(12'o0123, 31'h2AAA_5555, 1'b1, "r0123_bad_parity");
        do_read(12'o0301, line_vals[1], 1'b0, "r0301_good_parity");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
